// File: rtl/neuron_argmax.sv
// Purpose: picks the highest signed neuron score. Ties resolve to the lowest index.
// Latency: done pulses NUM_NEURONS-1 cycles after start is accepted (9 cycles by default).
// Backpressure: start is ignored while busy. There is no queue; a held start re-arms on each DONE cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   IN_SCORES  packed scores, neuron n at [n*OUTPUT_WIDTH +: OUTPUT_WIDTH] (signed, Q8.18)
//   start      classify request, sampled in IDLE or DONE
//   busy       high while a scan is running
//   done       one-cycle pulse; CLASS and MAX_SCORE are valid
//   CLASS      index of the winning neuron (registered, held until the next result)
//   MAX_SCORE  score of the winning neuron (registered, held until the next result)
module neuron_argmax #(
    parameter int NUM_NEURONS  = 10,
    parameter int OUTPUT_WIDTH = 26,
    parameter int IDX_WIDTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] IN_SCORES,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [IDX_WIDTH-1:0]                CLASS,
    output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    state_t                  state_q, state_d;
    logic [OUTPUT_WIDTH-1:0] bank_q [NUM_NEURONS];
    logic [OUTPUT_WIDTH-1:0] bank_d [NUM_NEURONS];
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [OUTPUT_WIDTH-1:0] best_score_q, best_score_d;
    logic [IDX_WIDTH-1:0]    best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0]    class_q, class_d;
    logic [OUTPUT_WIDTH-1:0] max_q, max_d;

    logic [OUTPUT_WIDTH-1:0] cur_score;
    logic                    cur_better;

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        idx_d        = idx_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        class_d      = class_q;
        max_d        = max_q;

        cur_score  = bank_q[idx_q];
        // A strict compare keeps the earlier (lower) index on ties.
        cur_better = $signed(cur_score) > $signed(best_score_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    // Snapshot the whole score vector, so later input changes cannot disturb the scan.
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        bank_d[n] = IN_SCORES[n*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                    end
                    best_score_d = IN_SCORES[OUTPUT_WIDTH-1:0];
                    best_idx_d   = '0;
                    idx_d        = IDX_WIDTH'(1);
                    if (NUM_NEURONS == 1) begin
                        // With a single neuron, neuron 0 is the result and no scan is needed.
                        state_d = S_DONE;
                        class_d = '0;
                        max_d   = IN_SCORES[OUTPUT_WIDTH-1:0];
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (cur_better) begin
                    best_score_d = cur_score;
                    best_idx_d   = idx_q;
                end
                idx_d = idx_q + IDX_WIDTH'(1);
                if (idx_q == LAST_IDX) begin
                    // The final compare is folded into the result, so no extra cycle is spent.
                    state_d = S_DONE;
                    class_d = cur_better ? idx_q : best_idx_q;
                    max_d   = cur_better ? cur_score : best_score_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            class_q      <= '0;
            max_q        <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                bank_q[n] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            class_q      <= class_d;
            max_q        <= max_d;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                bank_q[n] <= bank_d[n];
            end
        end
    end

    assign busy      = (state_q == S_SCAN);
    assign done      = (state_q == S_DONE);
    assign CLASS     = class_q;
    assign MAX_SCORE = max_q;

endmodule

// File: tb/tb_neuron_argmax.sv
// Purpose: randomized and directed scoreboard bench for neuron_argmax.
// Latency: expects each result NUM_NEURONS-1 cycles after the accepting edge.
// Backpressure: models start as ignored while a scan runs.
module tb_neuron_argmax;

    localparam int N  = 10;
    localparam int W  = 26;
    localparam int IW = 4;

    typedef struct {
        logic [IW-1:0] cls;
        logic [W-1:0]  mx;
        int            due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N*W-1:0] in_scores = '0;
    logic           busy;
    logic           done;
    logic [IW-1:0]  cls;
    logic [W-1:0]   mx;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   scan_left = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    neuron_argmax #(
        .NUM_NEURONS (N),
        .OUTPUT_WIDTH(W),
        .IDX_WIDTH   (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .IN_SCORES(in_scores),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .CLASS    (cls),
        .MAX_SCORE(mx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: find the largest signed value, then the first neuron holding it.
    function automatic void ref_argmax(input logic [N*W-1:0] v, output int c, output logic [W-1:0] m);
        longint best = 0;
        c = 0;
        for (int n = 0; n < N; n++) begin
            longint s = longint'($signed(v[n*W +: W]));
            if (n == 0 || s > best) best = s;
        end
        for (int n = N - 1; n >= 0; n--) begin
            if (longint'($signed(v[n*W +: W])) == best) c = n;
        end
        m = v[c*W +: W];
    endfunction

    // Transaction model: a scan occupies N-1 edges after acceptance, and start is honoured only when free.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_left = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (scan_left > 0) begin
                scan_left--;
            end else if (start) begin
                exp_t e;
                int c;
                logic [W-1:0] m;
                ref_argmax(in_scores, c, m);
                e.cls = IW'(c);
                e.mx  = m;
                e.due = cyc + N - 1;
                exp_q.push_back(e);
                scan_left = N - 1;
            end
        end
    end

    // Monitor: each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: done=1 at cycle %0d, expected no result pending", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("class", 64'(cls), 64'(mon_e.cls));
                check("max_score", 64'(mx), 64'(mon_e.mx));
                check("done_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || scan_left != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        tick(1);
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic randomize_scores();
        for (int n = 0; n < N; n++) in_scores[n*W +: W] = W'($urandom);
        if ($urandom_range(0, 2) == 0) begin
            int a = $urandom_range(0, N - 1);
            int b = $urandom_range(0, N - 1);
            in_scores[b*W +: W] = in_scores[a*W +: W];
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int d0;
        #2 rst = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_class", 64'(cls), 64'd0);
        check("reset_max", 64'(mx), 64'd0);
        tick(3);
        rst = 1'b1;

        // Single peak at neuron 7 (+3.5).
        in_scores = '0;
        in_scores[7*W +: W] = 26'h00E0000;
        pulse_start();
        drain(30);
        check("peak_class", 64'(cls), 64'd7);
        check("peak_max", 64'(mx), 64'h00E0000);

        // All negative scores, which exercises the signed compare.
        for (int n = 0; n < N; n++) in_scores[n*W +: W] = W'(-(n + 1) * 262144);
        pulse_start();
        drain(30);
        check("neg_class", 64'(cls), 64'd0);
        check("neg_max", 64'(mx), 64'h3FC0000);

        // Tie between neurons 2 and 8: the lower index wins.
        in_scores = '0;
        in_scores[2*W +: W] = 26'h0100000;
        in_scores[8*W +: W] = 26'h0100000;
        pulse_start();
        drain(30);
        check("tie_class", 64'(cls), 64'd2);

        // Inputs change and start pulses during a scan: the original snapshot must win.
        in_scores = '0;
        in_scores[3*W +: W] = 26'h0080000;
        d0 = done_cnt;
        pulse_start();
        in_scores[9*W +: W] = 26'h1000000;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drain(30);
        check("snap_class", 64'(cls), 64'd3);
        check("snap_max", 64'(mx), 64'h0080000);
        check("snap_done_count", 64'(done_cnt - d0), 64'd1);

        // Reset mid-scan clears outputs at once, and no done pulse follows.
        in_scores = '0;
        in_scores[5*W +: W] = 26'h0040000;
        pulse_start();
        tick(3);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_class", 64'(cls), 64'd0);
        check("abort_max", 64'(mx), 64'd0);
        d0 = done_cnt;
        tick(2);
        rst = 1'b1;
        tick(20);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_idle_busy", 64'(busy), 64'd0);

        // Randomized runs, some with stray start pulses and input churn mid-scan.
        for (int t = 0; t < 20; t++) begin
            randomize_scores();
            pulse_start();
            if ($urandom_range(0, 1) == 1) begin
                tick($urandom_range(0, 5));
                randomize_scores();
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            drain(30);
        end

        // Back-to-back: start held for 30 edges, with new scores every cycle.
        d0 = done_cnt;
        @(negedge clk);
        randomize_scores();
        start = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            check("b2b_busy", 64'(busy), 64'(((j % N) == N - 1) ? 0 : 1));
            check("b2b_done", 64'(done), 64'(((j % N) == N - 1) ? 1 : 0));
            randomize_scores();
            if (j == 29) start = 1'b0;
        end
        drain(30);
        check("b2b_done_count", 64'(done_cnt - d0), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
